run_controller: RTL and testbench

Host-side sequencer that sits directly upstream of the processor datapath and drives its START input while consuming its DONE output. It holds the datapath parked in reset between runs and applies a clean START pulse of programmable length when the host requests a run. It then counts execution cycles until DONE, and reports completion, the cycle count and an optional watchdog timeout to the host.

---
 rtl/definitions.sv | 22 ++
 rtl/sat_counter.sv | 32 +++
 rtl/run_controller.sv | 149 ++++++++++++++
 tb/tb_run_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions.sv
// Shared definitions for the run_controller block.
//   run_state_t : sequencer states (IDLE, INIT, RUN, REPORT)
//   INIT_CNT_W  : width of the inline INIT down-counter (INIT_CYCLES <= 255)
//   init_load() : value loaded into the INIT counter when a run is accepted
package definitions;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } run_state_t;

  localparam int INIT_CNT_W = 8;

  // The counter counts down to zero inclusive, so it starts one below the
  // number of INIT cycles wanted.
  function automatic logic [INIT_CNT_W-1:0] init_load(input int cycles);
    return INIT_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Ports:
//   CLK    in  1  clock, rising edge
//   reset  in  1  asynchronous active-low reset (count -> 0)
//   clear  in  1  synchronous clear, has priority over enable
//   enable in  1  increment by one, holding at all-ones
//   count  out W  current count
//   at_max out 1  count is all-ones (further increments are absorbed)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = &count;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Host-side run sequencer for the processor datapath.
// Parks the datapath with START high, applies INIT_CYCLES of START after an
// accepted host_go, counts RUN cycles until DONE (or the optional watchdog),
// and reports completion with a one-cycle host_done pulse.
// Optional feature macro: RUN_CTRL_TIMEOUT_EN enables the RUN-cycle watchdog;
// without it host_timeout is tied low and TIMEOUT_CYCLES is only range-checked.
// Ports:
//   CLK          in  1      clock, rising edge
//   reset        in  1      asynchronous active-low reset
//   host_go      in  1      run request, sampled in IDLE only
//   host_abort   in  1      cancel, honoured in INIT and RUN
//   dp_done      in  1      DONE from the datapath
//   dp_start     out 1      START to the datapath (low only in RUN)
//   host_busy    out 1      high in INIT, RUN and REPORT
//   host_done    out 1      one-cycle completion pulse (REPORT)
//   host_timeout out 1      run ended by watchdog, valid with host_done
//   host_cycles  out CNT_W  RUN-cycle count of the last completed run
module run_controller
  import definitions::*;
#(
  parameter int          INIT_CYCLES    = 2,
  parameter int          CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 32'hFFFF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             host_go,
  input  logic             host_abort,
  input  logic             dp_done,
  output logic             dp_start,
  output logic             host_busy,
  output logic             host_done,
  output logic             host_timeout,
  output logic [CNT_W-1:0] host_cycles
);

  // Elaboration-time parameter sanity checks.
  if (INIT_CYCLES < 1 || INIT_CYCLES > 255) begin : g_bad_init_cycles
    $error("run_controller: INIT_CYCLES must be 1..255");
  end
  if (longint'(TIMEOUT_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_timeout
    $error("run_controller: TIMEOUT_CYCLES exceeds counter range");
  end

  localparam logic [INIT_CNT_W-1:0] INIT_LOAD = init_load(INIT_CYCLES);

  run_state_t            state;
  logic [INIT_CNT_W-1:0] init_cnt;

  logic             run_clear;
  logic             run_enable;
  logic [CNT_W-1:0] run_count;
  logic             run_at_max;
  logic [CNT_W-1:0] run_now;
  logic             watchdog_hit;

  // The counter is held clear throughout INIT so the first RUN cycle starts
  // from zero; it only advances while in RUN.
  assign run_clear  = (state == INIT);
  assign run_enable = (state == RUN);

  sat_counter #(
    .W(CNT_W)
  ) u_run_cnt (
    .CLK   (CLK),
    .reset (reset),
    .clear (run_clear),
    .enable(run_enable),
    .count (run_count),
    .at_max(run_at_max)
  );

  // Count including the current RUN cycle (saturating), so that DONE in the
  // first RUN cycle reports 1.
  assign run_now = run_at_max ? run_count : run_count + 1'b1;

`ifdef RUN_CTRL_TIMEOUT_EN
  logic timeout_flag;
  assign watchdog_hit = (run_now == CNT_W'(TIMEOUT_CYCLES));
  assign host_timeout = timeout_flag;
`else
  assign watchdog_hit = 1'b0;
  assign host_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      init_cnt    <= '0;
      dp_start    <= 1'b1;
      host_busy   <= 1'b0;
      host_done   <= 1'b0;
      host_cycles <= '0;
`ifdef RUN_CTRL_TIMEOUT_EN
      timeout_flag <= 1'b0;
`endif
    end else begin
      host_done <= 1'b0;
      case (state)
        IDLE: begin
          // A simultaneous abort is meaningless here; go always wins.
          if (host_go) begin
            state     <= INIT;
            init_cnt  <= INIT_LOAD;
            host_busy <= 1'b1;
          end
        end
        INIT: begin
          if (host_abort) begin
            state     <= IDLE;
            init_cnt  <= '0;
            host_busy <= 1'b0;
          end else if (init_cnt == '0) begin
            state    <= RUN;
            dp_start <= 1'b0;
          end else begin
            init_cnt <= init_cnt - 1'b1;
          end
        end
        RUN: begin
          // Abort beats done, and done beats the watchdog.
          if (host_abort) begin
            state     <= IDLE;
            dp_start  <= 1'b1;
            host_busy <= 1'b0;
          end else if (dp_done || watchdog_hit) begin
            state       <= REPORT;
            dp_start    <= 1'b1;
            host_done   <= 1'b1;
            host_cycles <= run_now;
`ifdef RUN_CTRL_TIMEOUT_EN
            timeout_flag <= !dp_done;
`endif
          end
        end
        REPORT: begin
          state     <= IDLE;
          host_busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          dp_start  <= 1'b1;
          host_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller. A run is described by the RUN cycle
// on which dp_done rises (0 = never) and the RUN cycle on which host_abort is
// raised (0 = never); the expected outcome is computed from those numbers.
module tb_run_controller;

  localparam int INIT_CYCLES = 2;
  localparam int CNT_W       = 5;
  localparam int TIMEOUT     = 20;
  localparam int MAXC        = (1 << CNT_W) - 1;
  localparam int NEVER       = 100000;
`ifdef RUN_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic             host_go = 1'b0;
  logic             host_abort = 1'b0;
  logic             dp_done = 1'b0;
  logic             dp_start;
  logic             host_busy;
  logic             host_done;
  logic             host_timeout;
  logic [CNT_W-1:0] host_cycles;

  int checks = 0;
  int passed = 0;

  logic [CNT_W-1:0] exp_cycles = '0;
  logic             exp_timeout = 1'b0;

  always #5 CLK = ~CLK;

  run_controller #(
    .INIT_CYCLES   (INIT_CYCLES),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .host_go     (host_go),
    .host_abort  (host_abort),
    .dp_done     (dp_done),
    .dp_start    (dp_start),
    .host_busy   (host_busy),
    .host_done   (host_done),
    .host_timeout(host_timeout),
    .host_cycles (host_cycles)
  );

  // One complete run. d: RUN cycle where dp_done rises; a: RUN cycle of abort.
  task automatic run_one(input int d, input int a, input bit done_in_init, input string tag);
    int lim, fin, dd, aa;
    bit aborted;
    logic [CNT_W-1:0] want_cycles;
    logic             want_timeout;
    logic [2:0]       obs;
    dd  = (d == 0) ? NEVER : d;
    aa  = (a == 0) ? NEVER : a;
    lim = TO_EN ? TIMEOUT : NEVER;
    fin = lim;
    if (dd < fin) fin = dd;
    aborted = 1'b0;
    want_cycles  = exp_cycles;
    want_timeout = exp_timeout;
    if (aa <= fin) begin
      fin = aa;
      aborted = 1'b1;
    end else if (dd <= fin) begin
      want_cycles  = CNT_W'((dd > MAXC) ? MAXC : dd);
      want_timeout = 1'b0;
    end else begin
      want_cycles  = CNT_W'(TIMEOUT);
      want_timeout = 1'b1;
    end

    // Request the run (a simultaneous abort in IDLE must be ignored).
    @(negedge CLK);
    host_go    = 1'b1;
    host_abort = 1'($urandom % 2);
    dp_done    = done_in_init ? 1'b1 : 1'($urandom % 2);

    for (int i = 1; i <= INIT_CYCLES; i++) begin
      @(negedge CLK);
      obs = {dp_start, host_busy, host_done};
      checks++;
      if (obs !== 3'b110) $display("FAIL %s init%0d start/busy/done=%b want 110", tag, i, obs);
      else passed++;
      host_go    = 1'($urandom % 2);
      host_abort = 1'b0;
      dp_done    = done_in_init ? 1'b1 : 1'($urandom % 2);
    end

    for (int r = 1; r <= fin; r++) begin
      @(negedge CLK);
      obs = {dp_start, host_busy, host_done};
      checks++;
      if (obs !== 3'b010) $display("FAIL %s run%0d start/busy/done=%b want 010", tag, r, obs);
      else passed++;
      host_go    = 1'($urandom % 2);
      dp_done    = (r >= dd);
      host_abort = (r == aa);
    end

    @(negedge CLK);
    host_abort = 1'b0;
    dp_done    = 1'b0;
    obs = {dp_start, host_busy, host_done};
    if (aborted) begin
      host_go = 1'b0;
      checks++;
      if (obs !== 3'b100) $display("FAIL %s abort start/busy/done=%b want 100", tag, obs);
      else passed++;
    end else begin
      host_go = 1'($urandom % 2);
      checks++;
      if (obs !== 3'b111) $display("FAIL %s report start/busy/done=%b want 111", tag, obs);
      else passed++;
    end
    checks++;
    if (host_cycles !== want_cycles)
      $display("FAIL %s cycles got %0d want %0d", tag, host_cycles, want_cycles);
    else passed++;
    checks++;
    if (host_timeout !== want_timeout)
      $display("FAIL %s timeout got %b want %b", tag, host_timeout, want_timeout);
    else passed++;
    exp_cycles  = want_cycles;
    exp_timeout = want_timeout;

    if (!aborted) begin
      @(negedge CLK);
      host_go = 1'b0;
      obs = {dp_start, host_busy, host_done};
      checks++;
      if (obs !== 3'b100) $display("FAIL %s idle start/busy/done=%b want 100", tag, obs);
      else passed++;
    end
    $display("run %s: done@%0d abort@%0d -> %s cycles=%0d timeout=%b", tag, d, a,
             aborted ? "aborted" : "reported", host_cycles, host_timeout);
  endtask

  task automatic test_reset();
    logic [CNT_W+3:0] obs;
    @(negedge CLK);
    obs = {dp_start, host_busy, host_done, host_timeout, host_cycles};
    checks++;
    if (obs !== {4'b1000, CNT_W'(0)}) $display("FAIL reset outputs got %h want %h", obs, {4'b1000, CNT_W'(0)});
    else passed++;
    reset = 1'b1;
    exp_cycles  = '0;
    exp_timeout = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_basic();
    run_one(10, 0, 1'b0, "basic");
  endtask

  task automatic test_done_in_init();
    run_one(1, 0, 1'b1, "done_in_init");
  endtask

  task automatic test_timeout();
    // Without the watchdog the run would never end, so it is aborted instead.
    run_one(0, TO_EN ? 0 : 30, 1'b0, "no_done");
    run_one(20, 0, 1'b0, "done_at_limit");
  endtask

  task automatic test_abort();
    logic [2:0] obs;
    run_one(10, 0, 1'b0, "pre_abort");
    run_one(3, 3, 1'b0, "abort_run3");
    // Abort during INIT.
    @(negedge CLK);
    host_go = 1'b1;
    @(negedge CLK);
    host_go    = 1'b0;
    host_abort = 1'b1;
    @(negedge CLK);
    host_abort = 1'b0;
    obs = {dp_start, host_busy, host_done};
    checks++;
    if (obs !== 3'b100) $display("FAIL abort_init start/busy/done=%b want 100", obs);
    else passed++;
    checks++;
    if (host_cycles !== exp_cycles) $display("FAIL abort_init cycles got %0d want %0d", host_cycles, exp_cycles);
    else passed++;
    $display("run abort_init: cycles=%0d", host_cycles);
  endtask

  task automatic test_saturate();
    run_one(40, 0, 1'b0, "saturate");
  endtask

  task automatic test_random();
    int d, a;
    for (int n = 0; n < 14; n++) begin
      d = $urandom_range(1, 35);
      a = ($urandom % 4 == 0) ? $urandom_range(1, 35) : 0;
      run_one(d, a, 1'($urandom % 2), "random");
    end
  endtask

  task automatic test_async_reset();
    logic [CNT_W+3:0] obs;
    @(negedge CLK);
    host_go = 1'b1;
    repeat (INIT_CYCLES + 3) begin
      @(negedge CLK);
      host_go = 1'b0;
    end
    checks++;
    if (dp_start !== 1'b0) $display("FAIL async_pre dp_start got %b want 0", dp_start);
    else passed++;
    #2 reset = 1'b0;
    #1;
    obs = {dp_start, host_busy, host_done, host_timeout, host_cycles};
    checks++;
    if (obs !== {4'b1000, CNT_W'(0)}) $display("FAIL async_reset outputs got %h want %h", obs, {4'b1000, CNT_W'(0)});
    else passed++;
    @(negedge CLK);
    reset = 1'b1;
    exp_cycles  = '0;
    exp_timeout = 1'b0;
    $display("async reset: applied mid-run");
    run_one(5, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done_in_init();
    test_timeout();
    test_abort();
    test_saturate();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
